// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave_pkg
// Description : Shared AXI encodings, widths and the slave FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_sram_slave_pkg;

    localparam int c_axburst_w = 2;
    localparam int c_axsize_w  = 3;

    localparam logic [c_axburst_w-1:0] c_burst_fixed = 2'b00;
    localparam logic [c_axburst_w-1:0] c_burst_incr  = 2'b01;
    localparam logic [c_axburst_w-1:0] c_burst_wrap  = 2'b10;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Next-beat byte address for FIXED, INCR and WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
(
    input  logic [31:0]            i_addr,
    input  logic [7:0]             i_len,
    input  logic [c_axsize_w-1:0]  i_size,
    input  logic [c_axburst_w-1:0] i_burst,
    output logic [31:0]            o_next_addr
);

    logic [31:0] w_incr;
    logic [31:0] w_wrap_mask;
    logic [31:0] w_sum;

    always_comb begin
        w_incr      = 32'd1 << i_size;
        // WRAP lengths are powers of two, so the window size minus one is a mask
        w_wrap_mask = (({24'd0, i_len} + 32'd1) << i_size) - 32'd1;
        w_sum       = i_addr + w_incr;
        case (i_burst)
            c_burst_fixed: o_next_addr = i_addr;
            c_burst_incr:  o_next_addr = w_sum;
            c_burst_wrap:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
            default:       o_next_addr = w_sum;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : Single-outstanding AXI3 slave backed by a 32-bit word SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int          ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic [3:0]             arid,
    input  logic [31:0]            araddr,
    input  logic [7:0]             arlen,
    input  logic [c_axsize_w-1:0]  arsize,
    input  logic [c_axburst_w-1:0] arburst,
    input  logic [1:0]             arlock,
    input  logic [3:0]             arcache,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [3:0]             rid,
    output logic [31:0]            rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic [3:0]             awid,
    input  logic [31:0]            awaddr,
    input  logic [7:0]             awlen,
    input  logic [c_axsize_w-1:0]  awsize,
    input  logic [c_axburst_w-1:0] awburst,
    input  logic [1:0]             awlock,
    input  logic [3:0]             awcache,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [3:0]             wid,
    input  logic [31:0]            wdata,
    input  logic [3:0]             wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [3:0]             bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready
);

    localparam int c_depth = 1 << ADDR_W;

    logic [31:0]            r_mem [c_depth];
    state_e                 r_state, w_state_nxt;
    logic                   r_prio_wr;
    logic [3:0]             r_id;
    logic [31:0]            r_addr;
    logic [7:0]             r_len, r_beat;
    logic [c_axsize_w-1:0]  r_size;
    logic [c_axburst_w-1:0] r_burst;
    logic                   r_err, r_rvalid, r_rlast, r_bvalid;
    logic [31:0]            r_rdata;
    logic [1:0]             r_rresp, r_bresp;

    logic        w_grant_rd, w_grant_wr, w_r_hs, w_w_hs;
    logic        w_rd_ok, w_wr_ok, w_beat_err;
    logic [31:0] w_next_addr, w_rd_src, w_rd_word;
    logic        w_unused_ok;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> (ADDR_W + 2)) == 32'd0);
    endfunction

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        return ADDR_W'((a - BASE) >> 2);
    endfunction

    axi_burst_addr_gen u_addr_gen (
        .i_addr      (r_addr),
        .i_len       (r_len),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Contested requests go to whichever side r_prio_wr favours
    assign w_grant_rd = (r_state == ST_IDLE) && !rst && arvalid && (!awvalid || !r_prio_wr);
    assign w_grant_wr = (r_state == ST_IDLE) && !rst && awvalid && (!arvalid || r_prio_wr);
    assign w_r_hs     = r_rvalid && rready;
    assign w_w_hs     = (r_state == ST_WR) && wvalid;

    // The next read word is fetched from the incoming address on AR, else from the advanced address
    assign w_rd_src   = (r_state == ST_IDLE) ? araddr : w_next_addr;
    assign w_rd_ok    = in_range(w_rd_src);
    assign w_rd_word  = r_mem[word_idx(w_rd_src)];
    assign w_wr_ok    = in_range(r_addr);
    assign w_beat_err = !w_wr_ok || (wlast && (r_beat != r_len));

    assign arready = w_grant_rd;
    assign awready = w_grant_wr;
    assign rid     = r_id;
    assign bid     = r_id;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;
    assign rvalid  = r_rvalid;
    assign bresp   = r_bresp;
    assign bvalid  = r_bvalid;

    assign w_unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_rd) begin
                    w_state_nxt = ST_RD;
                end else if (w_grant_wr) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                if (w_r_hs && r_rlast) w_state_nxt = ST_IDLE;
            end
            ST_WR: begin
                wready = 1'b1;
                if (wvalid && wlast) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (r_bvalid && bready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_prio_wr <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_okay;
        end else begin
            if (arvalid && awvalid && (w_grant_rd || w_grant_wr)) r_prio_wr <= !r_prio_wr;
            if (w_grant_rd) begin
                r_id     <= arid;
                r_addr   <= araddr;
                r_len    <= arlen;
                r_size   <= arsize;
                r_burst  <= arburst;
                r_beat   <= '0;
                r_rvalid <= 1'b1;
                r_rlast  <= (arlen == 8'd0);
                r_rdata  <= w_rd_ok ? w_rd_word : '0;
                r_rresp  <= w_rd_ok ? c_resp_okay : c_resp_slverr;
            end else if (w_grant_wr) begin
                r_id    <= awid;
                r_addr  <= awaddr;
                r_len   <= awlen;
                r_size  <= awsize;
                r_burst <= awburst;
                r_beat  <= '0;
                r_err   <= 1'b0;
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end else begin
                    r_addr  <= w_next_addr;
                    r_beat  <= r_beat + 8'd1;
                    r_rlast <= ((r_beat + 8'd1) == r_len);
                    r_rdata <= w_rd_ok ? w_rd_word : '0;
                    r_rresp <= w_rd_ok ? c_resp_okay : c_resp_slverr;
                end
            end else if (w_w_hs) begin
                r_addr <= w_next_addr;
                if (r_beat != 8'hFF) r_beat <= r_beat + 8'd1;
                r_err  <= r_err || w_beat_err;
                if (wlast) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= (r_err || w_beat_err) ? c_resp_slverr : c_resp_okay;
                end
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Memory has no reset so its contents survive a mid-burst reset
    always_ff @(posedge aclk) begin
        if (w_w_hs && w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) r_mem[word_idx(r_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Directed self-checking bench for axi_sram_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic        aclk = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  arid = '0,   awid = '0,   wid = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0,  awlen = '0;
    logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
    logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0;
    logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic        arready, awready, wready, rvalid, rlast, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int checks = 0;
    int errors = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_d [16];
    logic [1:0]  rd_r [16];
    logic        rd_l [16];
    logic [3:0]  rd_id [16];

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
        .aclk(aclk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, output bit to);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        to = !arready;
        step();
        arvalid = 1'b0;
    endtask

    task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, output bit to);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin step(); n++; end
        to = !awready;
        step();
        awvalid = 1'b0;
    endtask

    task automatic rd_collect(input int nb, output bit to);
        int n;
        to = 1'b0;
        rready = 1'b1;
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (!rvalid && n < 20) begin step(); n++; end
            if (!rvalid) to = 1'b1;
            rd_d[b] = rdata; rd_r[b] = rresp; rd_l[b] = rlast; rd_id[b] = rid;
            step();
        end
        rready = 1'b0;
    endtask

    task automatic w_send(input int nb, output logic [1:0] resp, output logic [3:0] bid_o, output bit to);
        int n;
        to = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == nb - 1); wvalid = 1'b1;
            #1;
            n = 0;
            while (!wready && n < 20) begin step(); n++; end
            if (!wready) to = 1'b1;
            step();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        if (!bvalid) to = 1'b1;
        resp = bresp; bid_o = bid;
        step();
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nb,
                            output logic [1:0] resp, output logic [3:0] bid_o, output bit to);
        bit t1, t2;
        aw_issue(id, addr, len, burst, t1);
        w_send(nb, resp, bid_o, t2);
        to = t1 | t2;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output bit to);
        bit t1, t2;
        ar_issue(id, addr, len, burst, t1);
        rd_collect(int'(len) + 1, t2);
        to = t1 | t2;
    endtask

    task automatic test_reset();
        rst = 1'b1; arvalid = 1'b1; awvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000", {arready, awready, wready, rvalid, rlast, bvalid});
        checks++;
        if ({rdata, rid, bid, rresp, bresp} !== 44'd0)
            $display("FAIL reset_data got %h want 0", {rdata, rid, bid, rresp, bresp});
        if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0) errors++;
        if ({rdata, rid, bid, rresp, bresp} !== 44'd0) errors++;
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_strobe();
        logic [1:0] r; logic [3:0] b; bit to;
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
        wd[1] = 32'h0000_0000; ws[1] = 4'hF;
        do_write(4'd5, BASE + 32'h40, 8'd1, 2'b01, 2, r, b, to);
        checks++;
        if (to || r !== 2'b00 || b !== 4'd5) begin
            errors++; $display("FAIL preload_resp got to=%0d bresp=%b bid=%0d want 0/00/5", to, r, b);
        end
        wd[0] = 32'h1122_3344; ws[0] = 4'b0011;
        wd[1] = 32'hCAFE_F00D; ws[1] = 4'b1111;
        do_write(4'd9, BASE + 32'h40, 8'd1, 2'b01, 2, r, b, to);
        checks++;
        if (to || r !== 2'b00) begin errors++; $display("FAIL strobe_bresp got to=%0d %b want 00", to, r); end
        checks++;
        if (b !== 4'd9) begin errors++; $display("FAIL strobe_bid got %0d want 9", b); end
        do_read(4'd1, BASE + 32'h40, 8'd1, 2'b01, to);
        checks++;
        if (to || rd_d[0] !== 32'hAABB_3344) begin
            errors++; $display("FAIL strobe_word0 got %h want aabb3344", rd_d[0]);
        end
        checks++;
        if (rd_d[1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL strobe_word1 got %h want cafef00d", rd_d[1]); end
        checks++;
        if ({rd_l[0], rd_l[1]} !== 2'b01) begin errors++; $display("FAIL strobe_rlast got %b want 01", {rd_l[0], rd_l[1]}); end
    endtask

    task automatic test_incr_read();
        logic [1:0] r; logic [3:0] b; bit to;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0004 + i; ws[i] = 4'hF; end
        do_write(4'd2, BASE + 32'h10, 8'd3, 2'b01, 4, r, b, to);
        checks++;
        if (to || r !== 2'b00) begin errors++; $display("FAIL incr_fill_bresp got to=%0d %b want 00", to, r); end
        do_read(4'd3, BASE + 32'h10, 8'd3, 2'b01, to);
        checks++;
        if (to) begin errors++; $display("FAIL incr_timeout got 1 want 0"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_d[i] !== 32'hA000_0004 + i || rd_l[i] !== (i == 3) || rd_r[i] !== 2'b00 || rd_id[i] !== 4'd3) begin
                errors++;
                $display("FAIL incr_beat%0d got data=%h last=%b resp=%b id=%0d want %h/%b/00/3",
                         i, rd_d[i], rd_l[i], rd_r[i], rd_id[i], 32'hA000_0004 + i, (i == 3));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [4];
        bit to;
        exp_d[0] = 32'hA000_0006; exp_d[1] = 32'hA000_0007;
        exp_d[2] = 32'hA000_0004; exp_d[3] = 32'hA000_0005;
        do_read(4'd4, BASE + 32'h18, 8'd3, 2'b10, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || rd_d[i] !== exp_d[i]) begin
                errors++; $display("FAIL wrap_beat%0d got %h want %h", i, rd_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_fixed();
        logic [1:0] r; logic [3:0] b; bit to;
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
        do_write(4'd1, BASE + 32'h80, 8'd2, 2'b00, 3, r, b, to);
        do_read(4'd1, BASE + 32'h80, 8'd1, 2'b00, to);
        checks++;
        if (to || rd_d[0] !== 32'd3 || rd_d[1] !== 32'd3) begin
            errors++; $display("FAIL fixed_word got %h %h want 3 3", rd_d[0], rd_d[1]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [3:0] b; bit to;
        do_read(4'd6, BASE + 32'h400, 8'd0, 2'b01, to);
        checks++;
        if (to || rd_r[0] !== 2'b10 || rd_d[0] !== 32'd0 || rd_l[0] !== 1'b1) begin
            errors++; $display("FAIL oor_high_read got resp=%b data=%h last=%b want 10/0/1", rd_r[0], rd_d[0], rd_l[0]);
        end
        do_read(4'd6, BASE - 32'h4, 8'd0, 2'b01, to);
        checks++;
        if (to || rd_r[0] !== 2'b10 || rd_d[0] !== 32'd0) begin
            errors++; $display("FAIL oor_low_read got resp=%b data=%h want 10/0", rd_r[0], rd_d[0]);
        end
        do_read(4'd6, BASE + 32'h3FC, 8'd1, 2'b01, to);
        checks++;
        if (to || rd_r[0] !== 2'b00 || rd_r[1] !== 2'b10 || rd_d[1] !== 32'd0) begin
            errors++; $display("FAIL oor_cross got resp=%b,%b data1=%h want 00,10/0", rd_r[0], rd_r[1], rd_d[1]);
        end
        wd[0] = 32'h0; wd[1] = 32'h0; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(4'd7, BASE + 32'h60, 8'd3, 2'b01, 2, r, b, to);
        checks++;
        if (to || r !== 2'b10 || b !== 4'd7) begin
            errors++; $display("FAIL early_wlast got bresp=%b bid=%0d want 10/7", r, b);
        end
        wd[0] = 32'h1234_5678;
        do_write(4'd8, BASE, 8'd0, 2'b01, 1, r, b, to);
        wd[0] = 32'hDEAD_BEEF;
        do_write(4'd8, BASE + 32'h400, 8'd0, 2'b01, 1, r, b, to);
        checks++;
        if (to || r !== 2'b10) begin errors++; $display("FAIL oor_write_bresp got %b want 10", r); end
        do_read(4'd8, BASE, 8'd0, 2'b01, to);
        checks++;
        if (to || rd_d[0] !== 32'h1234_5678) begin
            errors++; $display("FAIL oor_write_dropped got %h want 12345678", rd_d[0]);
        end
    endtask

    task automatic test_arbiter();
        logic [1:0] r; logic [3:0] b; bit to;
        rst = 1'b1; step(); step(); rst = 1'b0; step();
        arid = 4'd1; araddr = BASE + 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'd2; awaddr = BASE + 32'h90; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin errors++; $display("FAIL grant1 got %b want 10", {arready, awready}); end
        step(); arvalid = 1'b0;
        rd_collect(1, to);
        checks++;
        if (to || rd_d[0] !== 32'hA000_0004) begin errors++; $display("FAIL grant1_data got %h want a0000004", rd_d[0]); end
        arvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b01) begin errors++; $display("FAIL grant2 got %b want 01", {arready, awready}); end
        step(); awvalid = 1'b0;
        wd[0] = 32'h0000_0055; ws[0] = 4'hF;
        w_send(1, r, b, to);
        checks++;
        if (to || r !== 2'b00 || b !== 4'd2) begin errors++; $display("FAIL grant2_resp got %b/%0d want 00/2", r, b); end
        awvalid = 1'b1;
        #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin errors++; $display("FAIL grant3 got %b want 10", {arready, awready}); end
        step(); arvalid = 1'b0; awvalid = 1'b0;
        rd_collect(1, to);
        checks++;
        if (to || rd_id[0] !== 4'd1) begin errors++; $display("FAIL grant3_rid got %0d want 1", rd_id[0]); end
    endtask

    task automatic test_stall_reset();
        bit to;
        ar_issue(4'd3, BASE + 32'h10, 8'd3, 2'b01, to);
        rready = 1'b1;
        checks++;
        if (to || rvalid !== 1'b1 || rdata !== 32'hA000_0004) begin
            errors++; $display("FAIL stall_beat0 got valid=%b data=%h want 1/a0000004", rvalid, rdata);
        end
        step();
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 32'hA000_0005 || rlast !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got valid=%b data=%h last=%b want 1/a0000005/0", i, rvalid, rdata, rlast);
            end
            step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rvalid, bvalid, wready, rlast} !== 4'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL stall_rst got ctrl=%b data=%h want 0000/0", {rvalid, bvalid, wready, rlast}, rdata);
        end
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if ({rvalid, bvalid, wready} !== 3'b0) begin
            errors++; $display("FAIL post_rst_idle got %b want 000", {rvalid, bvalid, wready});
        end
        do_read(4'd2, BASE + 32'h14, 8'd0, 2'b01, to);
        checks++;
        if (to || rd_d[0] !== 32'hA000_0005 || rd_l[0] !== 1'b1) begin
            errors++; $display("FAIL post_rst_read got %h last=%b want a0000005/1", rd_d[0], rd_l[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_strobe();
        test_incr_read();
        test_wrap();
        test_fixed();
        test_errors();
        test_arbiter();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
